// File: rtl/vga_cell_sampler_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_cell_sampler_if
// Description : Request, pixel-stream and result bundle of the cell sampler.
//               master = sequencer / VGA side (drives req, X, Y and the
//               scanned pixel), slave = the sampler (drives the result).
//   req        start pulse, X/Y captured with it
//   X, Y       cell origin column / row
//   VGA_X/Y    coordinate of the pixel being scanned out
//   VGA_COLOR  24-bit colour of that pixel
//   plot       VGA_X, VGA_Y, VGA_COLOR valid this cycle
//   busy, done, cell_state, uniform, error, white_cnt, blue_cnt : result
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_cell_sampler_if;
  logic        req;
  logic [9:0]  X;
  logic [8:0]  Y;
  logic [9:0]  VGA_X;
  logic [8:0]  VGA_Y;
  logic [23:0] VGA_COLOR;
  logic        plot;
  logic        busy;
  logic        done;
  logic        cell_state;
  logic        uniform;
  logic        error;
  logic [9:0]  white_cnt;
  logic [9:0]  blue_cnt;

  modport master (
    output req, X, Y, VGA_X, VGA_Y, VGA_COLOR, plot,
    input  busy, done, cell_state, uniform, error, white_cnt, blue_cnt
  );

  modport slave (
    input  req, X, Y, VGA_X, VGA_Y, VGA_COLOR, plot,
    output busy, done, cell_state, uniform, error, white_cnt, blue_cnt
  );
endinterface
`default_nettype wire

// File: rtl/vga_cell_sampler.sv
`default_nettype none
// ============================================================================
// Module      : vga_cell_sampler
// Description : Samples one SIZE x SIZE grid cell from the scanned-out VGA
//               pixel stream, counts white and blue pixels and reports
//               whether the cell reads as on (white majority) or off.
//   CLOCK_50   system clock, rising edge
//   Reset      synchronous active-high reset
//   bus        vga_cell_sampler_if.slave (request, pixel stream, result)
// Revision    : 1.0 - initial release
// ============================================================================
module vga_cell_sampler #(
  parameter int unsigned SIZE  = 31,
  parameter logic [23:0] WHITE = 24'hFFFFFF,
  parameter logic [23:0] BLUE  = 24'h0000FF,
  parameter int unsigned H_MAX = 639,
  parameter int unsigned V_MAX = 479
) (
  input wire logic          CLOCK_50,
  input wire logic          Reset,
  vga_cell_sampler_if.slave bus
);

  localparam logic [10:0] c_SPAN    = 11'(SIZE - 1);
  localparam logic [10:0] c_H_MAX   = 11'(H_MAX);
  localparam logic [10:0] c_V_MAX   = 11'(V_MAX);
  localparam logic [9:0]  c_AREA    = 10'(SIZE * SIZE);
  localparam logic [9:0]  c_HALF    = 10'((SIZE * SIZE) / 2);
  localparam logic [9:0]  c_CNT_MAX = 10'h3FF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    SCAN     = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [9:0]  r_ox;
  logic [8:0]  r_oy;
  logic [9:0]  r_white;
  logic [9:0]  r_blue;
  logic        r_cell_state;
  logic        r_uniform;
  logic        r_error;
  logic [9:0]  r_white_cnt;
  logic [9:0]  r_blue_cnt;

  logic [10:0] w_req_x_end;
  logic [10:0] w_req_y_end;
  logic        w_req_bad;
  logic [10:0] w_x_end;
  logic [10:0] w_y_end;
  logic        w_sof;
  logic        w_in_win;
  logic        w_last;
  logic        w_accept;
  logic        w_reject;
  logic        w_eval;
  logic        w_restart;
  logic        w_finish;
  logic [9:0]  w_white_nxt;
  logic [9:0]  w_blue_nxt;

  // Window extents are formed at 11 bits so an origin near the screen edge
  // cannot wrap back into range.
  assign w_req_x_end = {1'b0, bus.X} + c_SPAN;
  assign w_req_y_end = {2'b0, bus.Y} + c_SPAN;
  assign w_req_bad   = (w_req_x_end > c_H_MAX) || (w_req_y_end > c_V_MAX);

  assign w_x_end  = {1'b0, r_ox} + c_SPAN;
  assign w_y_end  = {2'b0, r_oy} + c_SPAN;
  assign w_sof    = bus.plot && (bus.VGA_X == 10'd0) && (bus.VGA_Y == 9'd0);
  assign w_in_win = (bus.VGA_X >= r_ox) && ({1'b0, bus.VGA_X} <= w_x_end) &&
                    (bus.VGA_Y >= r_oy) && ({2'b0, bus.VGA_Y} <= w_y_end);
  assign w_last   = ({1'b0, bus.VGA_X} == w_x_end) && ({2'b0, bus.VGA_Y} == w_y_end);

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    w_eval      = 1'b0;
    w_restart   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req) begin
          if (w_req_bad) begin
            w_reject    = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = WAIT_SOF;
          end
        end
      end
      // The start-of-frame pixel itself belongs to the frame being sampled.
      WAIT_SOF: begin
        if (w_sof) begin
          w_restart   = 1'b1;
          w_eval      = 1'b1;
          w_state_nxt = SCAN;
        end
      end
      // A new start-of-frame mid-window means the previous frame was cut
      // short; counting restarts from this frame.
      SCAN: begin
        if (bus.plot) begin
          w_restart = w_sof;
          w_eval    = 1'b1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
    if (w_eval && w_in_win && w_last) begin
      w_finish    = 1'b1;
      w_state_nxt = DONE;
    end
  end

  // Counter values including the pixel on the bus this cycle, so the final
  // pixel is already part of the result captured on the finishing edge.
  always_comb begin
    w_white_nxt = w_restart ? 10'd0 : r_white;
    w_blue_nxt  = w_restart ? 10'd0 : r_blue;
    if (w_eval && w_in_win) begin
      if (bus.VGA_COLOR == WHITE) begin
        if (w_white_nxt != c_CNT_MAX) begin
          w_white_nxt = w_white_nxt + 10'd1;
        end
      end else if (bus.VGA_COLOR == BLUE) begin
        if (w_blue_nxt != c_CNT_MAX) begin
          w_blue_nxt = w_blue_nxt + 10'd1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_ox         <= 10'd0;
      r_oy         <= 9'd0;
      r_white      <= 10'd0;
      r_blue       <= 10'd0;
      r_cell_state <= 1'b0;
      r_uniform    <= 1'b0;
      r_error      <= 1'b0;
      r_white_cnt  <= 10'd0;
      r_blue_cnt   <= 10'd0;
    end else begin
      if (w_accept) begin
        r_ox    <= bus.X;
        r_oy    <= bus.Y;
        r_white <= 10'd0;
        r_blue  <= 10'd0;
      end else if (w_eval) begin
        r_white <= w_white_nxt;
        r_blue  <= w_blue_nxt;
      end

      if (w_reject) begin
        r_error      <= 1'b1;
        r_white_cnt  <= 10'd0;
        r_blue_cnt   <= 10'd0;
        r_cell_state <= 1'b0;
        r_uniform    <= 1'b0;
      end else if (w_finish) begin
        r_error      <= 1'b0;
        r_white_cnt  <= w_white_nxt;
        r_blue_cnt   <= w_blue_nxt;
        r_cell_state <= (w_white_nxt > c_HALF);
        r_uniform    <= (w_white_nxt == c_AREA) || (w_blue_nxt == c_AREA);
      end
    end
  end

  assign bus.busy       = (r_state == WAIT_SOF) || (r_state == SCAN);
  assign bus.done       = (r_state == DONE);
  assign bus.cell_state = r_cell_state;
  assign bus.uniform    = r_uniform;
  assign bus.error      = r_error;
  assign bus.white_cnt  = r_white_cnt;
  assign bus.blue_cnt   = r_blue_cnt;

endmodule
`default_nettype wire
